// File: rtl/disparity_search_mt.sv
// -----------------------------------------------------------------------------
// disparity_search_mt
//
// Purpose:
//   Multi-lane disparity search for one pixel column. The left WINxWIN window
//   starts at col_index. For each candidate disparity d the right window starts
//   at col_index+d. LANES candidates are scored in parallel per group with a
//   sum-of-absolute-differences tree each. The lowest SAD among in-bounds
//   candidates wins, and a tie goes to the lowest disparity. The search covers
//   d = 0..disp_limit. It can stop early once a perfect match (SAD 0) is seen.
//   The result is offered through a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   input_array_L   left strip,  pixel[r][c] at bit DATA_SIZE*(r*IMG_W+c)
//   input_array_R   right strip, same packing (both held stable while busy)
//   start           request a search (only looked at in IDLE)
//   col_index       leftmost column of the left window
//   disp_limit      highest disparity searched, inclusive
//   early_exit_en   stop after the first group whose best SAD is 0
//   busy            high from LOAD through OUT
//   out_valid       result available (high in OUT)
//   out_ready       downstream accepts the result
//   output_disp     winning disparity
//   output_sad      SAD of the winner (all ones when nothing matched)
//   no_match        no candidate was inside the strip and the limit
// -----------------------------------------------------------------------------
module disparity_search_mt #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64,
  parameter int LANES     = 4,
  parameter int WIN_SIZE  = 225,
  parameter int SAD_BITS  = 16,
  parameter int DISP_BITS = 6,
  parameter int COL_BITS  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0] input_array_L,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0] input_array_R,
  input  logic                           start,
  input  logic [COL_BITS-1:0]            col_index,
  input  logic [DISP_BITS-1:0]           disp_limit,
  input  logic                           early_exit_en,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DISP_BITS-1:0]           output_disp,
  output logic [SAD_BITS-1:0]            output_sad,
  output logic                           no_match
);

  // Two spare bits let column + disparity + window sums stay exact.
  localparam int IDX_W = COL_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    COMPARE,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic [COL_BITS-1:0]  col_q;
  logic [DISP_BITS-1:0] limit_q;
  logic                 early_q;
  logic [IDX_W-1:0]     base_q;
  logic [SAD_BITS-1:0]  best_sad_q;
  logic [DISP_BITS-1:0] best_disp_q;
  logic                 found_q;
  logic [SAD_BITS-1:0]  lane_sad_q [LANES];

  logic [SAD_BITS-1:0]  lane_sad_d [LANES];
  logic [SAD_BITS-1:0]  best_sad_n;
  logic [DISP_BITS-1:0] best_disp_n;
  logic                 found_n;

  logic [IDX_W-1:0]     col_ext;
  logic [IDX_W-1:0]     limit_ext;
  logic [IDX_W-1:0]     lane_cand  [LANES];
  logic [IDX_W-1:0]     lane_start [LANES];
  logic [LANES-1:0]     lane_in;
  logic                 last_group;
  logic                 exit_group;

  logic [DATA_SIZE-1:0] pix_l [WIN][IMG_W];
  logic [DATA_SIZE-1:0] pix_r [WIN][IMG_W];

  function automatic logic [DATA_SIZE-1:0] abs_diff(input logic [DATA_SIZE-1:0] a,
                                                    input logic [DATA_SIZE-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Unpack the flat strips into row/column pixel arrays.
  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < IMG_W; c++) begin : g_col
      assign pix_l[r][c] = input_array_L[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE];
      assign pix_r[r][c] = input_array_R[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE];
    end
  end

  assign col_ext   = IDX_W'(col_q);
  assign limit_ext = IDX_W'(limit_q);

  // Candidate disparity and right-window start column per lane. A lane takes
  // part only if it is within the limit and its right window fits in the strip.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_cand[k]  = base_q + IDX_W'(k);
    assign lane_start[k] = col_ext + lane_cand[k];
    assign lane_in[k]    = (lane_cand[k] <= limit_ext) &&
                           ((lane_start[k] + IDX_W'(WIN - 1)) <= IDX_W'(IMG_W - 1));
  end

  // One SAD tree per lane. Column indices are truncated to the strip width.
  // A lane whose window runs off the strip therefore reads wrapped columns.
  // That lane never takes part in the compare, so its sum is never used.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_sad_d[k] = '0;
      for (int p = 0; p < WIN_SIZE; p++) begin
        lane_sad_d[k] = lane_sad_d[k] + SAD_BITS'(abs_diff(
          pix_l[p / WIN][COL_BITS'(col_ext + IDX_W'(p % WIN))],
          pix_r[p / WIN][COL_BITS'(lane_start[k] + IDX_W'(p % WIN))]));
      end
    end
  end

  // Fold the registered lane SADs into the running best, lowest lane first.
  // Strict less-than keeps the earlier (lower) disparity on a tie.
  always_comb begin
    best_sad_n  = best_sad_q;
    best_disp_n = best_disp_q;
    found_n     = found_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_in[k]) begin
        found_n = 1'b1;
        if (lane_sad_q[k] < best_sad_n) begin
          best_sad_n  = lane_sad_q[k];
          best_disp_n = DISP_BITS'(lane_cand[k]);
        end
      end
    end
  end

  // The search ends when the next group would start past the limit, or when
  // early exit is on and a perfect match has been found.
  assign last_group = ((base_q + IDX_W'(LANES)) > limit_ext) ||
                      ((base_q + IDX_W'(LANES)) >= IDX_W'(MAX_DISP));
  assign exit_group = last_group || (early_q && (best_sad_n == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        busy    = 1'b1;
        state_d = COMPARE;
      end
      COMPARE: begin
        busy    = 1'b1;
        state_d = exit_group ? OUT : COMPUTE;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers. The result registers load only when a search ends,
  // so they stay frozen while the result waits in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      limit_q     <= '0;
      early_q     <= 1'b0;
      base_q      <= '0;
      best_sad_q  <= '1;
      best_disp_q <= '0;
      found_q     <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        lane_sad_q[k] <= '0;
      end
      output_disp <= '0;
      output_sad  <= '1;
      no_match    <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          col_q       <= col_index;
          limit_q     <= disp_limit;
          early_q     <= early_exit_en;
          base_q      <= '0;
          best_sad_q  <= '1;
          best_disp_q <= '0;
          found_q     <= 1'b0;
        end
        COMPUTE: begin
          for (int k = 0; k < LANES; k++) begin
            lane_sad_q[k] <= lane_sad_d[k];
          end
        end
        COMPARE: begin
          best_sad_q  <= best_sad_n;
          best_disp_q <= best_disp_n;
          found_q     <= found_n;
          if (exit_group) begin
            output_disp <= best_disp_n;
            output_sad  <= best_sad_n;
            no_match    <= !found_n;
          end else begin
            base_q <= base_q + IDX_W'(LANES);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_search_mt.sv
// -----------------------------------------------------------------------------
// tb_disparity_search_mt
//
// Purpose:
//   Directed self-checking bench for disparity_search_mt. The strip patterns
//   are simple enough that the expected disparity, SAD and latency can be
//   worked out by hand.
//
// Ports: none (top-level bench)
// -----------------------------------------------------------------------------
module tb_disparity_search_mt;

  localparam int WIN       = 15;
  localparam int DATA_SIZE = 8;
  localparam int IMG_W     = 64;
  localparam int MAX_DISP  = 64;
  localparam int LANES     = 4;
  localparam int WIN_SIZE  = 225;
  localparam int SAD_BITS  = 16;
  localparam int DISP_BITS = 6;
  localparam int COL_BITS  = 6;
  localparam int STRIP     = DATA_SIZE * IMG_W * WIN;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [STRIP-1:0]     strip_l = '0;
  logic [STRIP-1:0]     strip_r = '0;
  logic [STRIP-1:0]     rand_strip = '0;
  logic                 start = 1'b0;
  logic [COL_BITS-1:0]  col_index = '0;
  logic [DISP_BITS-1:0] disp_limit = '0;
  logic                 early_exit_en = 1'b0;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DISP_BITS-1:0] output_disp;
  logic [SAD_BITS-1:0]  output_sad;
  logic                 no_match;

  int tests_run    = 0;
  int tests_failed = 0;

  disparity_search_mt #(
    .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP),
    .LANES(LANES), .WIN_SIZE(WIN_SIZE), .SAD_BITS(SAD_BITS),
    .DISP_BITS(DISP_BITS), .COL_BITS(COL_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_array_L(strip_l),
    .input_array_R(strip_r),
    .start(start),
    .col_index(col_index),
    .disp_limit(disp_limit),
    .early_exit_en(early_exit_en),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_disp(output_disp),
    .output_sad(output_sad),
    .no_match(no_match)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Identical random strips: only d=0 gives SAD 0.
  task automatic fillEqual();
    strip_l = rand_strip;
    strip_r = rand_strip;
  endtask

  // L[r][c]=2c, R[r][c+5]=L[r][c]: SAD(d) = 225*|2(d-5)| while the window stays in range.
  task automatic fillShift();
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        strip_l[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = 8'(2 * c);
        strip_r[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = (c >= 5) ? 8'(2 * (c - 5)) : 8'd0;
      end
    end
  endtask

  // Period-8 row pattern with L==R: d=0 and d=8 both give SAD 0.
  task automatic fillPeriod8();
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        strip_l[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = 8'((c % 8) * 30 + r);
        strip_r[DATA_SIZE*(r*IMG_W+c) +: DATA_SIZE] = 8'((c % 8) * 30 + r);
      end
    end
  endtask

  // Launch one search and count clock edges from the start-sampling edge until
  // out_valid is seen. The wait is bounded.
  task automatic applyStimulus(input logic [COL_BITS-1:0] col, input logic [DISP_BITS-1:0] lim,
                               input logic early, output int lat);
    @(negedge clk);
    col_index     = col;
    disp_limit    = lim;
    early_exit_en = early;
    start         = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_in_load", 32'(busy), 32'd1);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Run a search with out_ready held high and check the result, then check
  // that the block is idle again one cycle later.
  task automatic runCheck(input string tag, input logic [COL_BITS-1:0] col,
                          input logic [DISP_BITS-1:0] lim, input logic early,
                          input int exp_lat, input int exp_disp, input int exp_sad,
                          input int exp_nm);
    int lat;
    applyStimulus(col, lim, early, lat);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".disp"}, 32'(output_disp), 32'(exp_disp));
    checkOutput({tag, ".sad"}, 32'(output_sad), 32'(exp_sad));
    checkOutput({tag, ".no_match"}, 32'(no_match), 32'(exp_nm));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    for (int i = 0; i < IMG_W * WIN; i++) begin
      rand_strip[DATA_SIZE*i +: DATA_SIZE] = 8'($urandom_range(0, 255));
    end

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.valid", 32'(out_valid), 32'd0);
    checkOutput("reset.no_match", 32'(no_match), 32'd0);
    checkOutput("reset.disp", 32'(output_disp), 32'd0);
    checkOutput("reset.sad", 32'(output_sad), 32'hFFFF);

    // T1: identical strips, full search, G=16.
    fillEqual();
    runCheck("t1", 6'd10, 6'd63, 1'b0, 34, 0, 0, 0);
    // Same data with early exit stops after the first group.
    runCheck("t1_early", 6'd10, 6'd63, 1'b1, 4, 0, 0, 0);
    // Limit 0: a single group with one participating lane.
    runCheck("t1_lim0", 6'd10, 6'd0, 1'b0, 4, 0, 0, 0);

    // T2: shifted strips, exact match at d=5.
    fillShift();
    runCheck("t2_early", 6'd10, 6'd20, 1'b1, 6, 5, 0, 0);
    runCheck("t2_full", 6'd10, 6'd20, 1'b0, 14, 5, 0, 0);
    // d=5 excluded by the limit: best is d=4 with SAD 225*2.
    runCheck("t2_lim4", 6'd10, 6'd4, 1'b0, 6, 4, 450, 0);
    runCheck("t2_lim5", 6'd10, 6'd5, 1'b0, 6, 5, 0, 0);

    // T3: column bounds. Only d=0 fits at col 49 (SAD 225*10). Nothing fits at col 50.
    runCheck("t3_col49", 6'd49, 6'd63, 1'b0, 34, 0, 2250, 0);
    runCheck("t3_col50", 6'd50, 6'd63, 1'b0, 34, 0, 16'hFFFF, 1);

    // T4: tie between d=0 and d=8 resolves to the lower disparity.
    fillPeriod8();
    runCheck("t4", 6'd10, 6'd15, 1'b0, 10, 0, 0, 0);

    // T5: stalled result stays frozen and a start during OUT is ignored.
    fillShift();
    out_ready = 1'b0;
    applyStimulus(6'd10, 6'd20, 1'b1, lat);
    checkOutput("t5.latency", 32'(lat), 32'd6);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(posedge clk);
      @(negedge clk);
      checkOutput("t5.hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t5.hold_disp", 32'(output_disp), 32'd5);
      checkOutput("t5.hold_sad", 32'(output_sad), 32'd0);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t5.release_valid", 32'(out_valid), 32'd0);
    checkOutput("t5.release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5.start_ignored", 32'(busy), 32'd0);
    runCheck("t5_next", 6'd10, 6'd4, 1'b0, 6, 4, 450, 0);

    // T6: reset in the COMPUTE cycle of group 3, then a clean rerun of T1.
    fillEqual();
    @(negedge clk);
    col_index     = 6'd10;
    disp_limit    = 6'd63;
    early_exit_en = 1'b0;
    start         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("t6.busy_before", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t6.rst_busy", 32'(busy), 32'd0);
    checkOutput("t6.rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6.rst_no_match", 32'(no_match), 32'd0);
    checkOutput("t6.rst_disp", 32'(output_disp), 32'd0);
    checkOutput("t6.rst_sad", 32'(output_sad), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    runCheck("t6_rerun", 6'd10, 6'd63, 1'b0, 34, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
